fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_VECTOR, 16'h0000, PC loaded on reset.
REQ-002 Parameter INT_VECTOR, 16'h0002, PC loaded when an interrupt is taken.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; all state is cleared while low.
REQ-005 stall  input  1  hazard hold from decode; freezes PC, state and IF/ID outputs.
REQ-006 redirect_en  input  1  taken jump/call/ret from a later stage; flushes fetch.
REQ-007 redirect_pc  input  16  redirect target address.
REQ-008 interruptSignal  input  1  external interrupt request, level input, edge-detected.
REQ-009 imem_addr  output  16  instruction memory address; equals PC combinationally.
REQ-010 imem_data  input  16  instruction memory read data, valid in the same cycle as imem_addr.
REQ-011 if_id_valid  output  1  IF/ID register holds a real instruction; 0 = bubble.
REQ-012 if_id_instr  output  16  instruction word (opcode in bits 15:11).
REQ-013 if_id_imm  output  16  immediate word for two-word instructions, else 0.
REQ-014 if_id_has_imm  output  1  if_id_imm is meaningful.
REQ-015 if_id_pc_next  output  16  address following the instruction (return address for CALL/INT).
REQ-016 int_taken  output  1  one-cycle pulse when the synthetic INT instruction is issued.

Function
REQ-017 States: FETCH_OP, FETCH_IMM; reset state FETCH_OP.
REQ-018 FETCH_OP, opcode not LDM: register imem_data into if_id_instr, set if_id_valid=1, if_id_has_imm=0, if_id_imm=0, if_id_pc_next=PC+1; PC<=PC+1.
REQ-019 FETCH_OP, opcode LDM (5'b01100): hold word internally, emit bubble (if_id_valid=0), PC<=PC+1, go FETCH_IMM.
REQ-020 FETCH_IMM: emit held word with if_id_imm=imem_data, if_id_has_imm=1, if_id_valid=1, if_id_pc_next=PC+1; PC<=PC+1; go FETCH_OP.
REQ-021 Latency: a word read at PC in cycle N appears on if_id_* after edge N (one cycle).
REQ-022 PC arithmetic is 16-bit modulo; PC=16'hFFFF increments to 16'h0000.
REQ-023 stall=1: PC, state, held word and all if_id_* outputs hold their values; the interrupt edge latch still updates.
REQ-024 redirect_en=1: PC<=redirect_pc, state<=FETCH_OP, held word discarded, if_id_valid<=0; redirect overrides stall.
REQ-025 Rising edge of interruptSignal sets int_pending; further edges while pending are merged.
REQ-026 Interrupt taken only in FETCH_OP with int_pending=1, stall=0, redirect_en=0: emit if_id_instr=OP_INT word, if_id_valid=1, if_id_pc_next=PC (un-fetched address), PC<=INT_VECTOR, int_pending<=0, int_taken=1 for one cycle.
REQ-027 Interrupt pending in FETCH_IMM waits until the second word is issued; two-word instructions are never split.
REQ-028 Interrupt and redirect in the same cycle: redirect wins, interrupt stays pending, return address becomes redirect_pc.

Reset
REQ-029 While reset=0: PC=RESET_VECTOR, state=FETCH_OP, int_pending=0, edge history=0, held word=0, all if_id_* outputs=0, int_taken=0.
REQ-030 Reset asserted mid-FETCH_IMM abandons the partial instruction; first fetch after release is at RESET_VECTOR.

Structure
REQ-031 Opcode constants (OP_LDM, OP_INT, OP_NOP), opcode field position and the state encoding live in the shared processor defines package.
REQ-032 Interrupt edge detection and pending flag form one sub-module, int_latch.

Verification
REQ-033 Reset release, memory 0:D000, 1:D100 -> if_id_instr D000 then D100, pc_next 1 then 2, valid=1 both.
REQ-034 Memory 0:6500, 1:0006 -> cycle 1 bubble, cycle 2 instr=6500, imm=0006, has_imm=1, pc_next=2.
REQ-035 stall held 3 cycles at PC=4 -> imem_addr stays 4, if_id_* unchanged; resumes at PC=4 after release.
REQ-036 redirect_en with redirect_pc=0x34 during FETCH_IMM -> next output bubble, then instruction from 0x34, held LDM discarded.
REQ-037 interruptSignal pulse while at PC=5 -> INT word issued, pc_next=5, int_taken one cycle, next fetch at 0x0002.
REQ-038 interruptSignal pulse during FETCH_IMM at PC=1 -> LDM completes first, then INT with pc_next=2.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared processor defines: opcode field, opcode constants and fetch state encoding.
package fetch_stage_pkg;

  localparam int unsigned OPCODE_MSB = 15;
  localparam int unsigned OPCODE_LSB = 11;

  localparam logic [4:0] OP_NOP = 5'b00000;
  localparam logic [4:0] OP_LDM = 5'b01100;
  localparam logic [4:0] OP_INT = 5'b11111;

  typedef enum logic {
    FETCH_OP  = 1'b0,
    FETCH_IMM = 1'b1
  } fetchState_t;

  function automatic logic [4:0] opcodeOf(input logic [15:0] word);
    return word[OPCODE_MSB:OPCODE_LSB];
  endfunction

  function automatic logic [15:0] opWord(input logic [4:0] op);
    return {op, 11'b0};
  endfunction

endpackage

// File: rtl/fetch_stage_int_latch.sv
// Interrupt request edge detector with a sticky pending flag; edges while pending merge.
module int_latch (
  input  logic clk,
  input  logic reset,
  input  logic interruptSignal,
  input  logic clearPending,
  output logic intPending
);

  logic prevSignal;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prevSignal <= 1'b0;
      intPending <= 1'b0;
    end else begin
      prevSignal <= interruptSignal;
      intPending <= (interruptSignal & ~prevSignal) | (intPending & ~clearPending);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, two-word LDM assembly, redirect flush and interrupt injection.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [15:0] RESET_VECTOR = 16'h0000,
  parameter logic [15:0] INT_VECTOR   = 16'h0002
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [15:0] redirect_pc,
  input  logic        interruptSignal,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  output logic        if_id_valid,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_imm,
  output logic        if_id_has_imm,
  output logic [15:0] if_id_pc_next,
  output logic        int_taken
);

  fetchState_t state;
  logic [15:0] pc;
  logic [15:0] heldWord;
  logic        intPending;
  logic        takeInt;

  assign imem_addr = pc;

  // Interrupts only enter between instructions, never while a redirect or stall is active.
  assign takeInt = (state == FETCH_OP) && intPending && !stall && !redirect_en;

  int_latch uIntLatch (
    .clk            (clk),
    .reset          (reset),
    .interruptSignal(interruptSignal),
    .clearPending   (takeInt),
    .intPending     (intPending)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc            <= RESET_VECTOR;
      state         <= FETCH_OP;
      heldWord      <= opWord(OP_NOP);
      if_id_valid   <= 1'b0;
      if_id_instr   <= '0;
      if_id_imm     <= '0;
      if_id_has_imm <= 1'b0;
      if_id_pc_next <= '0;
      int_taken     <= 1'b0;
    end else begin
      int_taken <= takeInt;
      if (redirect_en) begin
        pc          <= redirect_pc;
        state       <= FETCH_OP;
        heldWord    <= opWord(OP_NOP);
        if_id_valid <= 1'b0;
      end else if (!stall) begin
        if (takeInt) begin
          // Return address is the not-yet-fetched PC.
          if_id_valid   <= 1'b1;
          if_id_instr   <= opWord(OP_INT);
          if_id_imm     <= '0;
          if_id_has_imm <= 1'b0;
          if_id_pc_next <= pc;
          pc            <= INT_VECTOR;
        end else if (state == FETCH_IMM) begin
          if_id_valid   <= 1'b1;
          if_id_instr   <= heldWord;
          if_id_imm     <= imem_data;
          if_id_has_imm <= 1'b1;
          if_id_pc_next <= pc + 16'd1;
          pc            <= pc + 16'd1;
          state         <= FETCH_OP;
        end else if (opcodeOf(imem_data) == OP_LDM) begin
          heldWord    <= imem_data;
          if_id_valid <= 1'b0;
          pc          <= pc + 16'd1;
          state       <= FETCH_IMM;
        end else begin
          if_id_valid   <= 1'b1;
          if_id_instr   <= imem_data;
          if_id_imm     <= '0;
          if_id_has_imm <= 1'b0;
          if_id_pc_next <= pc + 16'd1;
          pc            <= pc + 16'd1;
        end
      end
    end
  end

endmodule
